// File: rtl/divisor_secuencial.sv
// divisor_secuencial: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Subtraction uses the add-with-carry-in form A + ~B + 1 so it matches the ALU adder.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   inicio     start request, sampled only in IDLE
//   Dividendo  unsigned dividend, captured on acceptance
//   Divisor    unsigned divisor, captured on acceptance
//   Cociente   registered quotient (all ones on divide-by-zero)
//   Residuo    registered remainder (dividend on divide-by-zero)
//   ocupado    high while the iteration runs
//   listo      one-cycle pulse when a result is valid
//   div_cero   result flag: divisor was zero
module divisor_secuencial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inicio,
    input  logic [WIDTH-1:0] Dividendo,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Cociente,
    output logic [WIDTH-1:0] Residuo,
    output logic             ocupado,
    output logic             listo,
    output logic             div_cero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    // Partial remainder always stays below the divisor, so WIDTH bits hold it.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] cociente_q, cociente_d;
    logic [WIDTH-1:0] residuo_q, residuo_d;
    logic             div_cero_q, div_cero_d;
    logic             listo_q, listo_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // One restoring step; diff[WIDTH] set means the subtraction borrowed.
    always_comb begin
        rs     = {r_q, q_q[WIDTH-1]};
        diff   = rs + ~{1'b0, divisor_q} + One;
        r_step = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
        q_step = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        q_d        = q_q;
        divisor_d  = divisor_q;
        count_d    = count_q;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        div_cero_d = div_cero_q;
        listo_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (inicio) begin
                    if (Divisor != '0) begin
                        divisor_d = Divisor;
                        q_d       = Dividendo;
                        r_d       = '0;
                        count_d   = CntW'(WIDTH - 1);
                        state_d   = StCalc;
                    end else begin
                        cociente_d = '1;
                        residuo_d  = Dividendo;
                        div_cero_d = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StCalc: begin
                r_d     = r_step;
                q_d     = q_step;
                count_d = count_q - CntW'(1);
                if (count_q == '0) begin
                    cociente_d = q_step;
                    residuo_d  = r_step;
                    div_cero_d = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                // listo is registered, so it rises in the cycle after DONE.
                listo_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            r_q        <= '0;
            q_q        <= '0;
            divisor_q  <= '0;
            count_q    <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            div_cero_q <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            q_q        <= q_d;
            divisor_q  <= divisor_d;
            count_q    <= count_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            div_cero_q <= div_cero_d;
            listo_q    <= listo_d;
        end
    end

    assign Cociente = cociente_q;
    assign Residuo  = residuo_q;
    assign div_cero = div_cero_q;
    assign listo    = listo_q;
    assign ocupado  = (state_q == StCalc);

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: a scoreboard queue holds the expected
// quotient, remainder, flag and latency for each accepted request; the monitor pops
// one entry on every listo pulse.
module tb_divisor_secuencial;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         inicio = 1'b0;
    logic [W-1:0] dividendo = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] cociente;
    logic [W-1:0] residuo;
    logic         ocupado;
    logic         listo;
    logic         div_cero;

    divisor_secuencial #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .inicio    (inicio),
        .Dividendo (dividendo),
        .Divisor   (divisor),
        .Cociente  (cociente),
        .Residuo   (residuo),
        .ocupado   (ocupado),
        .listo     (listo),
        .div_cero  (div_cero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           listo_seen = 0;
    logic [W-1:0] last_q = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every listo pulse must match the oldest pending request.
    always @(negedge clk) begin : mon
        exp_t e;
        if (listo) begin
            listo_seen++;
            chk("pending_on_listo", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("cociente", 64'(cociente), 64'(e.q));
                chk("residuo", 64'(residuo), 64'(e.r));
                chk("div_cero", 64'(div_cero), 64'(e.dz));
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                last_q = e.q;
            end
        end
    end

    // Drive a request while the DUT is idle and record the expected result.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        dividend_set(a, b);
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        e.dz  = (b == '0);
        e.q   = e.dz ? '1 : a / b;
        e.r   = e.dz ? a : a % b;
        e.acc = cyc;
        e.lat = e.dz ? 1 : W + 1;
        sb.push_back(e);
    endtask

    task automatic dividend_set(input logic [W-1:0] a, input logic [W-1:0] b);
        dividendo = a;
        divisor   = b;
    endtask

    task automatic wait_done(output int busy);
        busy = 0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (ocupado) busy++;
        end
        chk("timeout", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin : main
        int busy;
        int seen_before;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_cociente", 64'(cociente), 64'd0);
        chk("rst_residuo", 64'(residuo), 64'd0);
        chk("rst_ocupado", 64'(ocupado), 64'd0);
        chk("rst_listo", 64'(listo), 64'd0);
        chk("rst_div_cero", 64'(div_cero), 64'd0);
        reset_n = 1'b1;

        // Basic division and busy duration.
        start(32'd100, 32'd7);
        wait_done(busy);
        chk("ocupado_cycles", 64'(busy), 64'(W));

        // Edge cases.
        start(32'd5, 32'd9);
        wait_done(busy);
        start(32'hFFFF_FFFF, 32'd1);
        wait_done(busy);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(busy);

        // Divide by zero, then a valid division clears the flag.
        start(32'h1234_5678, 32'd0);
        wait_done(busy);
        chk("dz_no_busy", 64'(busy), 64'd0);
        start(32'd77, 32'd8);
        wait_done(busy);

        // Second request and operand changes during CALC are ignored.
        start(32'd1000, 32'd10);
        repeat (3) @(negedge clk);
        dividend_set(32'd50, 32'd5);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        dividend_set(32'd7, 32'd1);
        @(negedge clk);
        chk("hold_during_calc", 64'(cociente), 64'(last_q));
        wait_done(busy);
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts it with no listo.
        seen_before = listo_seen;
        @(negedge clk);
        dividend_set(32'd1000, 32'd3);
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cociente", 64'(cociente), 64'd0);
        chk("abort_residuo", 64'(residuo), 64'd0);
        chk("abort_ocupado", 64'(ocupado), 64'd0);
        chk("abort_listo", 64'(listo), 64'd0);
        chk("abort_div_cero", 64'(div_cero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_listo", 64'(listo_seen), 64'(seen_before));
        start(32'd9, 32'd2);
        wait_done(busy);

        // Random regression with non-zero divisors.
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            case (n % 3)
                0:       b = $urandom_range(1, 255);
                1:       b = $urandom_range(1, 65535);
                default: b = $urandom;
            endcase
            if (b == '0) b = 32'd1;
            start(a, b);
            wait_done(busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
